// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluator: sweeps 64 OAM entries and emits the sprites that cover
// the requested line, in OAM order, flagging overflow past MAX_SPRITES hits.
module sprite_evaluator #(
   parameter int MAX_SPRITES   = 8,
   parameter int SPRITE_HEIGHT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  scanline,
   output logic [5:0]  oam_read_addr,
   input  logic [31:0] oam_read_data,
   output logic        busy,
   output logic        spr_valid,
   output logic [2:0]  spr_slot,
   output logic [8:0]  spr_x,
   output logic [7:0]  spr_tile,
   output logic [3:0]  spr_row,
   output logic        spr_hflip,
   output logic        spr_priority,
   output logic [3:0]  spr_palette,
   output logic        done,
   output logic [3:0]  count,
   output logic        overflow
);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2} state_t;

   localparam logic [3:0] SLOT_MAX = 4'(MAX_SPRITES);
   localparam logic [7:0] HEIGHT   = 8'(SPRITE_HEIGHT);
   localparam logic [3:0] ROW_MAX  = 4'(SPRITE_HEIGHT - 1);

   function automatic logic [8:0] line_delta(input logic [7:0] line, input logic [7:0] y);
      return {1'b0, line} - {1'b0, y};
   endfunction

   function automatic logic [3:0] sprite_row(input logic [3:0] d, input logic vflip);
      return vflip ? (ROW_MAX - d) : d;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  line_q;
   logic [5:0]  addr_q;
   logic        iss_q, dat_q, dat_last_q, eval_last_q;
   logic [3:0]  slot_q, count_q;
   logic        overflow_q;
   logic        spr_valid_q, spr_hflip_q, spr_priority_q;
   logic [2:0]  spr_slot_q;
   logic [8:0]  spr_x_q;
   logic [7:0]  spr_tile_q;
   logic [3:0]  spr_row_q, spr_palette_q;

   logic [8:0]  delta;
   logic        hit, accept, ovf;

   // Hit test on the entry returned this cycle; feeds registers only.
   always_comb begin
      delta  = line_delta(line_q, oam_read_data[7:0]);
      hit    = (state_q == SCAN) && dat_q && !delta[8] && (delta[7:0] < HEIGHT);
      accept = hit && (slot_q < SLOT_MAX);
      ovf    = hit && (slot_q >= SLOT_MAX);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (ovf || eval_last_q) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         line_q         <= '0;
         addr_q         <= '0;
         iss_q          <= 1'b0;
         dat_q          <= 1'b0;
         dat_last_q     <= 1'b0;
         eval_last_q    <= 1'b0;
         slot_q         <= '0;
         count_q        <= '0;
         overflow_q     <= 1'b0;
         spr_valid_q    <= 1'b0;
         spr_slot_q     <= '0;
         spr_x_q        <= '0;
         spr_tile_q     <= '0;
         spr_row_q      <= '0;
         spr_hflip_q    <= 1'b0;
         spr_priority_q <= 1'b0;
         spr_palette_q  <= '0;
      end else begin
         state_q     <= state_d;
         spr_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  line_q      <= scanline;
                  addr_q      <= '0;
                  iss_q       <= 1'b1;
                  dat_q       <= 1'b0;
                  dat_last_q  <= 1'b0;
                  eval_last_q <= 1'b0;
                  slot_q      <= '0;
                  count_q     <= '0;
                  overflow_q  <= 1'b0;
               end
            end
            SCAN: begin
               // Address issue -> data return -> evaluation, one valid bit per stage.
               if (iss_q && !ovf) begin
                  if (addr_q == 6'd63) iss_q <= 1'b0;
                  else                 addr_q <= addr_q + 6'd1;
               end
               dat_q       <= iss_q;
               dat_last_q  <= iss_q && (addr_q == 6'd63);
               eval_last_q <= dat_q && dat_last_q;
               if (accept) begin
                  spr_valid_q    <= 1'b1;
                  spr_slot_q     <= slot_q[2:0];
                  spr_x_q        <= oam_read_data[24:16];
                  spr_tile_q     <= oam_read_data[15:8];
                  spr_row_q      <= sprite_row(delta[3:0], oam_read_data[26]);
                  spr_hflip_q    <= oam_read_data[25];
                  spr_priority_q <= oam_read_data[27];
                  spr_palette_q  <= oam_read_data[31:28];
                  slot_q         <= slot_q + 4'd1;
               end
               if (ovf) begin
                  overflow_q  <= 1'b1;
                  iss_q       <= 1'b0;
                  dat_q       <= 1'b0;
                  dat_last_q  <= 1'b0;
                  eval_last_q <= 1'b0;
               end
               if (state_d == FIN) count_q <= slot_q;
            end
            default: begin
               iss_q       <= 1'b0;
               dat_q       <= 1'b0;
               dat_last_q  <= 1'b0;
               eval_last_q <= 1'b0;
            end
         endcase
      end
   end

   assign oam_read_addr = addr_q;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FIN);
   assign count         = count_q;
   assign overflow      = overflow_q;
   assign spr_valid     = spr_valid_q;
   assign spr_slot      = spr_slot_q;
   assign spr_x         = spr_x_q;
   assign spr_tile      = spr_tile_q;
   assign spr_row       = spr_row_q;
   assign spr_hflip     = spr_hflip_q;
   assign spr_priority  = spr_priority_q;
   assign spr_palette   = spr_palette_q;

endmodule

// File: tb/tb_sprite_evaluator.sv
// Scoreboard bench for sprite_evaluator: directed OAM images with hand-computed sprite records.
module tb_sprite_evaluator;

   typedef struct packed {
      int         cyc;
      logic [2:0] slot;
      logic [8:0] x;
      logic [7:0] tile;
      logic [3:0] row;
      logic       hflip;
      logic       pri;
      logic [3:0] pal;
   } spr_t;

   typedef struct packed {
      int         cyc;
      logic [3:0] cnt;
      logic       ovf;
   } done_t;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [7:0]  scanline;
   logic [5:0]  oam_read_addr;
   logic [31:0] oam_read_data;
   logic        busy, spr_valid, spr_hflip, spr_priority, done, overflow;
   logic [2:0]  spr_slot;
   logic [8:0]  spr_x;
   logic [7:0]  spr_tile;
   logic [3:0]  spr_row, spr_palette, count;

   logic [31:0] oam [64];
   int          cyc = 0, t0 = 0, checks = 0, errors = 0;
   spr_t        exp_spr [$];
   done_t       exp_done [$];
   spr_t        se, sa;
   done_t       de, da;

   always #5 clk = ~clk;

   sprite_evaluator #(.MAX_SPRITES(8), .SPRITE_HEIGHT(16)) dut (
      .clk(clk), .reset(reset), .start(start), .scanline(scanline),
      .oam_read_addr(oam_read_addr), .oam_read_data(oam_read_data),
      .busy(busy), .spr_valid(spr_valid), .spr_slot(spr_slot), .spr_x(spr_x),
      .spr_tile(spr_tile), .spr_row(spr_row), .spr_hflip(spr_hflip),
      .spr_priority(spr_priority), .spr_palette(spr_palette),
      .done(done), .count(count), .overflow(overflow)
   );

   // OAM model: one-cycle registered read.
   always @(posedge clk) oam_read_data <= oam[oam_read_addr];
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ent(input logic [7:0] y, input logic [7:0] tile,
                                       input logic [8:0] x, input logic hf, input logic vf,
                                       input logic pr, input logic [3:0] pal);
      return {pal, pr, vf, hf, x, tile, y};
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a sprite or done.
   always @(negedge clk) begin
      if (!reset) begin
         if (spr_valid) begin
            checks++;
            sa.cyc = cyc - t0; sa.slot = spr_slot; sa.x = spr_x; sa.tile = spr_tile;
            sa.row = spr_row; sa.hflip = spr_hflip; sa.pri = spr_priority; sa.pal = spr_palette;
            if (exp_spr.size() == 0) begin
               errors++;
               $display("FAIL spr_unexpected: got cycle=%0d slot=%0d x=%h tile=%h row=%0d, required no sprite",
                        sa.cyc, sa.slot, sa.x, sa.tile, sa.row);
            end else begin
               se = exp_spr.pop_front();
               if (sa !== se) begin
                  errors++;
                  $display("FAIL spr_record: got cyc=%0d slot=%0d x=%h tile=%h row=%0d hf=%b pr=%b pal=%h, required cyc=%0d slot=%0d x=%h tile=%h row=%0d hf=%b pr=%b pal=%h",
                           sa.cyc, sa.slot, sa.x, sa.tile, sa.row, sa.hflip, sa.pri, sa.pal,
                           se.cyc, se.slot, se.x, se.tile, se.row, se.hflip, se.pri, se.pal);
               end
            end
         end
         if (done) begin
            checks++;
            da.cyc = cyc - t0; da.cnt = count; da.ovf = overflow;
            if (exp_done.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: got done at cycle=%0d, required none", da.cyc);
            end else begin
               de = exp_done.pop_front();
               if (da !== de || spr_valid !== 1'b0 || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL done_event: got cyc=%0d count=%0d ovf=%b spr_valid=%b busy=%b, required cyc=%0d count=%0d ovf=%b spr_valid=0 busy=1",
                           da.cyc, da.cnt, da.ovf, spr_valid, busy, de.cyc, de.cnt, de.ovf);
               end
            end
         end
      end
   end

   task automatic push_spr(input int c, input int s, input logic [8:0] x, input logic [7:0] tile,
                           input logic [3:0] row, input logic hf, input logic pr, input logic [3:0] pal);
      spr_t e;
      e.cyc = c; e.slot = 3'(s); e.x = x; e.tile = tile; e.row = row;
      e.hflip = hf; e.pri = pr; e.pal = pal;
      exp_spr.push_back(e);
   endtask

   task automatic push_done(input int c, input int n, input logic ovf);
      done_t e;
      e.cyc = c; e.cnt = 4'(n); e.ovf = ovf;
      exp_done.push_back(e);
   endtask

   task automatic fill_oam(input logic [7:0] y);
      for (int i = 0; i < 64; i++) oam[i] = ent(y, 8'h00, 9'h000, 1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic start_scan(input logic [7:0] line);
      @(posedge clk); #1;
      start = 1'b1; scanline = line; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // Waits for done (bounded), then checks busy drops and results hold.
   task automatic finish_scan(input int n, input logic ovf);
      int k = 0;
      while (done !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done in 200 cycles, required done");
      end
      @(negedge clk);
      check("after_done", {busy, count, overflow}, {1'b0, 4'(n), ovf});
      repeat (3) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; scanline = 8'h00;
      fill_oam(8'hF0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state", {oam_read_addr, busy, spr_valid, done, count, overflow},
            {6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});

      // No sprite covers line 10.
      push_done(67, 0, 1'b0);
      start_scan(8'd10);
      @(negedge clk);
      check("busy_cycle1", {30'd0, busy, oam_read_addr == 6'd0}, 32'd3);
      finish_scan(0, 1'b0);
      check("addr_hold", {26'd0, oam_read_addr}, 32'd63);

      // Single sprite at entry 5, d = 7.
      oam[5] = ent(8'd20, 8'h42, 9'h123, 1'b0, 1'b0, 1'b0, 4'd3);
      push_spr(8, 0, 9'h123, 8'h42, 4'd7, 1'b0, 1'b0, 4'd3);
      push_done(67, 1, 1'b0);
      start_scan(8'd27);
      finish_scan(1, 1'b0);

      push_spr(8, 0, 9'h123, 8'h42, 4'd0, 1'b0, 1'b0, 4'd3);
      push_done(67, 1, 1'b0);
      start_scan(8'd20);
      finish_scan(1, 1'b0);

      // Vertical flip: row = 15 - d.
      oam[5] = ent(8'd20, 8'h42, 9'h123, 1'b0, 1'b1, 1'b0, 4'd3);
      push_spr(8, 0, 9'h123, 8'h42, 4'd8, 1'b0, 1'b0, 4'd3);
      push_done(67, 1, 1'b0);
      start_scan(8'd27);
      finish_scan(1, 1'b0);

      push_spr(8, 0, 9'h123, 8'h42, 4'd15, 1'b0, 1'b0, 4'd3);
      push_done(67, 1, 1'b0);
      start_scan(8'd20);
      finish_scan(1, 1'b0);

      push_done(67, 0, 1'b0);
      start_scan(8'd36);
      finish_scan(0, 1'b0);

      push_done(67, 0, 1'b0);
      start_scan(8'd19);
      finish_scan(0, 1'b0);

      // Ten hits on line 100: eight emitted, ninth (entry 8) overflows.
      fill_oam(8'hF0);
      for (int i = 0; i < 10; i++) oam[i] = ent(8'd100, 8'(i + 16), 9'(i * 3), 1'b0, 1'b0, 1'b0, 4'(i));
      for (int i = 0; i < 8; i++) push_spr(i + 3, i, 9'(i * 3), 8'(i + 16), 4'd0, 1'b0, 1'b0, 4'(i));
      push_done(11, 8, 1'b1);
      start_scan(8'd100);
      finish_scan(8, 1'b1);

      // No vertical wrap; Y = 250 covers 250..255 only.
      fill_oam(8'h80);
      oam[7] = ent(8'd250, 8'hA5, 9'h1FF, 1'b1, 1'b0, 1'b1, 4'hF);
      push_done(67, 0, 1'b0);
      start_scan(8'd3);
      finish_scan(0, 1'b0);

      push_spr(10, 0, 9'h1FF, 8'hA5, 4'd5, 1'b1, 1'b1, 4'hF);
      push_done(67, 1, 1'b0);
      start_scan(8'd255);
      finish_scan(1, 1'b0);

      // Reset mid-scan: hits at entries 10 and 20 are out before cycle 30, entry 40 is not.
      fill_oam(8'hF0);
      oam[10] = ent(8'd50, 8'h10, 9'h010, 1'b0, 1'b0, 1'b0, 4'd1);
      oam[20] = ent(8'd45, 8'h20, 9'h020, 1'b0, 1'b0, 1'b1, 4'd2);
      oam[40] = ent(8'd40, 8'h40, 9'h040, 1'b1, 1'b0, 1'b0, 4'd4);
      push_spr(13, 0, 9'h010, 8'h10, 4'd0, 1'b0, 1'b0, 4'd1);
      push_spr(23, 1, 9'h020, 8'h20, 4'd5, 1'b0, 1'b1, 4'd2);
      start_scan(8'd50);
      do begin @(posedge clk); #1; end while (cyc - t0 != 30);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_abort", {oam_read_addr, busy, spr_valid, done, count, overflow, spr_x},
            {6'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 9'd0});
      repeat (60) @(negedge clk);
      check("reset_spr_left", exp_spr.size(), 32'd0);

      // Clean rescan with a stray start at cycle 20 that must be ignored.
      push_spr(13, 0, 9'h010, 8'h10, 4'd0, 1'b0, 1'b0, 4'd1);
      push_spr(23, 1, 9'h020, 8'h20, 4'd5, 1'b0, 1'b1, 4'd2);
      push_spr(43, 2, 9'h040, 8'h40, 4'd10, 1'b1, 1'b0, 4'd4);
      push_done(67, 3, 1'b0);
      start_scan(8'd50);
      do begin @(posedge clk); #1; end while (cyc - t0 != 20);
      start = 1'b1; scanline = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      finish_scan(3, 1'b0);

      check("spr_queue_empty", exp_spr.size(), 32'd0);
      check("done_queue_empty", exp_done.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
